multi_ch_clk_div: RTL

//  - NUM_CH independent integer clock dividers driven by one reference clock.
//  - Used by the UART/link domains to derive per-channel baud and oversampling clocks.
//  - Adds features the single-channel divider lacks:
//    - ratio changes take effect only at a period boundary, so there are no runt pulses;
//    - disable is graceful: the current period finishes before the output stops;
//    - a common i_sync restarts all channels phase-aligned;
//    - a per-channel one-cycle rise tick for clock-enable style use.

---
 rtl/clk_div_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 127 ++++++++++++
 rtl/multi_ch_clk_div.sv | 34 +++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Holds the channel state encoding and the high-phase length rule.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        BYPASS = 2'd2
    } div_state_t;

    // High phase of an R-cycle period is ceil(R/2), so odd ratios get the extra cycle.
    function automatic logic [31:0] high_len(input logic [31:0] r);
        return (r >> 1) + {31'b0, r[0]};
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: state machine, period counter and glitch-free bypass mux.
// Ratio and enable changes are honoured only at period boundaries.
module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int RATIO_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sync,
    input  logic                   en,
    input  logic [RATIO_WIDTH-1:0] ratio,
    output logic                   div_clk,
    output logic                   rise_tick,
    output logic                   active
);

    localparam logic [RATIO_WIDTH-1:0] ONE = 1;

    div_state_t             state_q, state_d;
    logic [RATIO_WIDTH-1:0] cnt_q, cnt_d;
    logic [RATIO_WIDTH-1:0] ratio_q, ratio_d;
    logic                   div_q, div_d;
    logic                   tick_q, tick_d;
    logic                   active_q;
    logic                   byp_sel_q;
    logic                   byp_latch;
    logic                   period_end;

    assign period_end = (state_q == DIVIDE) && (cnt_q == (ratio_q - ONE));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ratio_d = ratio_q;
        div_d   = div_q;
        tick_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    ratio_d = ratio;
                    cnt_d   = '0;
                    tick_d  = 1'b1;
                    if (ratio > ONE) begin
                        state_d = DIVIDE;
                        div_d   = 1'b1;
                    end else begin
                        state_d = BYPASS;
                        div_d   = 1'b0;
                    end
                end
            end
            DIVIDE: begin
                if (period_end || sync) begin
                    cnt_d = '0;
                    if (!en) begin
                        state_d = IDLE;
                        div_d   = 1'b0;
                    end else begin
                        ratio_d = ratio;
                        tick_d  = 1'b1;
                        if (ratio > ONE) begin
                            div_d = 1'b1;
                        end else begin
                            state_d = BYPASS;
                            div_d   = 1'b0;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                    div_d = (32'(cnt_d) < high_len(32'(ratio_q)));
                end
            end
            BYPASS: begin
                div_d = 1'b0;
                if (!en) begin
                    state_d = IDLE;
                end else begin
                    ratio_d = ratio;
                    tick_d  = 1'b1;
                    if (ratio > ONE) begin
                        state_d = DIVIDE;
                        cnt_d   = '0;
                        div_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                div_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ratio_q   <= '0;
            div_q     <= 1'b0;
            tick_q    <= 1'b0;
            active_q  <= 1'b0;
            byp_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            div_q     <= div_d;
            tick_q    <= tick_d;
            active_q  <= (state_d != IDLE);
            byp_sel_q <= (state_d == BYPASS);
        end
    end

    // Select is only allowed to change while the reference clock is low, so the mux never chops a pulse.
    always_latch begin
        if (!clk) begin
            byp_latch <= byp_sel_q;
        end
    end

    assign div_clk   = byp_latch ? clk : div_q;
    assign rise_tick = tick_q;
    assign active    = active_q;

endmodule

// File: rtl/multi_ch_clk_div.sv
// NUM_CH independent integer clock dividers sharing one reference clock.
// A common sync pulse restarts every dividing channel phase-aligned.
module multi_ch_clk_div
    import clk_div_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int RATIO_WIDTH = 8
) (
    input  logic                          i_ref_clk,
    input  logic                          i_rst,
    input  logic                          i_sync,
    input  logic [NUM_CH-1:0]             i_clk_en,
    input  logic [NUM_CH*RATIO_WIDTH-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]             o_div_clk,
    output logic [NUM_CH-1:0]             o_rise_tick,
    output logic [NUM_CH-1:0]             o_active
);

    for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
        clk_div_channel #(
            .RATIO_WIDTH(RATIO_WIDTH)
        ) u_ch (
            .clk      (i_ref_clk),
            .rst      (i_rst),
            .sync     (i_sync),
            .en       (i_clk_en[g]),
            .ratio    (i_div_ratio[g*RATIO_WIDTH +: RATIO_WIDTH]),
            .div_clk  (o_div_clk[g]),
            .rise_tick(o_rise_tick[g]),
            .active   (o_active[g])
        );
    end

endmodule
